// File: rtl/multn_seq_if.sv
// Request/response bundle for the sequential multiplier.
// The requester drives start/tc/a/b; the multiplier returns busy/done/p.
interface multn_seq_if #(
    parameter int WIDTH = 4
);
    logic               start;
    logic               tc;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] p;

    modport master (output start, tc, a, b, input busy, done, p);
    modport slave  (input start, tc, a, b, output busy, done, p);
endinterface

// File: rtl/multn_seq.sv
// Sequential shift-add multiplier, WIDTH-bit operands, 2*WIDTH-bit product.
// Signed mode multiplies magnitudes and applies the sign once in FIN.
// Optional macro MULTN_EARLY_EN: leave CALC as soon as the remaining
// multiplier bits are all zero (no zero-detect logic without it).
module multn_seq #(
    parameter int WIDTH = 4
) (
    input  logic        ck,
    input  logic        res,
    multn_seq_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

    state_t             state;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] mcand;
    logic [WIDTH-1:0]   mult;
    logic               neg;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic [2*WIDTH-1:0] result;
    logic               busy_q;
    logic               done_q;
    logic [2*WIDTH-1:0] p_q;
`ifndef MULTN_EARLY_EN
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    logic [CW-1:0]      cnt;
`endif

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.p    = p_q;

    // Operand magnitudes; the most negative value maps to 2^(WIDTH-1),
    // which still fits as an unsigned WIDTH-bit number.
    always_comb begin
        mag_a = bus.a;
        mag_b = bus.b;
        if (bus.tc && bus.a[WIDTH-1]) mag_a = ~bus.a + WIDTH'(1);
        if (bus.tc && bus.b[WIDTH-1]) mag_b = ~bus.b + WIDTH'(1);
    end

    // Sign fix-up of the accumulated magnitude; negating zero yields zero.
    always_comb begin
        result = neg ? (~acc + (2*WIDTH)'(1)) : acc;
    end

    // Control FSM plus datapath; outputs are registered.
    always_ff @(posedge ck or posedge res) begin
        if (res) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            p_q    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mult   <= '0;
            neg    <= 1'b0;
`ifndef MULTN_EARLY_EN
            cnt    <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    busy_q <= 1'b0;
                    if (bus.start) begin
                        state  <= CALC;
                        busy_q <= 1'b1;
                        acc    <= '0;
                        mcand  <= {{WIDTH{1'b0}}, mag_a};
                        mult   <= mag_b;
                        neg    <= bus.tc & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
`ifndef MULTN_EARLY_EN
                        cnt    <= '0;
`endif
                    end
                end
                CALC: begin
`ifdef MULTN_EARLY_EN
                    // Remaining partial products are zero: result already final.
                    if (mult == '0) begin
                        state <= FIN;
                    end else begin
                        if (mult[0]) acc <= acc + mcand;
                        mcand <= mcand << 1;
                        mult  <= mult >> 1;
                    end
`else
                    if (mult[0]) acc <= acc + mcand;
                    mcand <= mcand << 1;
                    mult  <= mult >> 1;
                    if (cnt == CW'(WIDTH-1)) state <= FIN;
                    else                     cnt   <= cnt + CW'(1);
`endif
                end
                FIN: begin
                    p_q    <= result;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multn_seq.sv
// Self-checking bench: WIDTH=4 and WIDTH=8 instances, scoreboard queues
// filled at stimulus time and drained when done pulses.
module tb_multn_seq;
    typedef struct {
        longint p;
        int     acc;
        int     lat;
    } exp_t;

    logic ck = 1'b0;
    logic res = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q4[$];
    exp_t q8[$];

    multn_seq_if #(.WIDTH(4)) bus4();
    multn_seq_if #(.WIDTH(8)) bus8();

    multn_seq #(.WIDTH(4)) dut4 (.ck(ck), .res(res), .bus(bus4.slave));
    multn_seq #(.WIDTH(8)) dut8 (.ck(ck), .res(res), .bus(bus8.slave));

    always #5 ck = ~ck;

    always @(posedge ck) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint expv);
        checks++;
        if (got !== expv) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, expv);
        end
    endtask

    // Reference product: sign-extend operands in signed mode, multiply, truncate.
    function automatic longint ref_mul(int w, longint a, longint b, bit tc);
        longint av = a;
        longint bv = b;
        if (tc && ((a >> (w - 1)) & 1) == 1) av = a - (longint'(1) << w);
        if (tc && ((b >> (w - 1)) & 1) == 1) bv = b - (longint'(1) << w);
        return (av * bv) & ((longint'(1) << (2 * w)) - 1);
    endfunction

    // Cycles from accept edge until done is visible.
    function automatic int ref_lat(int w, longint b, bit tc);
`ifdef MULTN_EARLY_EN
        longint m = b;
        int hb = -1;
        if (tc && ((b >> (w - 1)) & 1) == 1) m = (longint'(1) << w) - b;
        if (m == 0) return 2;
        for (int i = 0; i < w; i++) if (((m >> i) & 1) == 1) hb = i;
        return hb + 3;
`else
        return w + 1;
`endif
    endfunction

    // Scoreboard drain for the WIDTH=4 instance.
    always @(negedge ck) begin : mon4
        exp_t e;
        if (bus4.done === 1'b1) begin
            if (q4.size() == 0) chk("w4_spurious_done", 1, 0);
            else begin
                e = q4.pop_front();
                chk("w4_p", longint'(bus4.p), e.p);
                chk("w4_latency", longint'(cyc - e.acc), longint'(e.lat));
            end
        end
    end

    // Scoreboard drain for the WIDTH=8 instance.
    always @(negedge ck) begin : mon8
        exp_t e;
        if (bus8.done === 1'b1) begin
            if (q8.size() == 0) chk("w8_spurious_done", 1, 0);
            else begin
                e = q8.pop_front();
                chk("w8_p", longint'(bus8.p), e.p);
                chk("w8_latency", longint'(cyc - e.acc), longint'(e.lat));
            end
        end
    end

    task automatic wait_idle4();
        int n = 0;
        while (bus4.busy === 1'b1 && n < 100) begin
            @(negedge ck);
            n++;
        end
        if (n >= 100) chk("w4_timeout", 1, 0);
        @(negedge ck);
    endtask

    task automatic wait_idle8();
        int n = 0;
        while (bus8.busy === 1'b1 && n < 100) begin
            @(negedge ck);
            n++;
        end
        if (n >= 100) chk("w8_timeout", 1, 0);
        @(negedge ck);
    endtask

    // One WIDTH=4 operation; also measures how long busy stays high.
    task automatic go4(input logic [3:0] a, input logic [3:0] b, input logic tc);
        exp_t e;
        int   nb = 0;
        @(negedge ck);
        bus4.start = 1'b1; bus4.a = a; bus4.b = b; bus4.tc = tc;
        e.p = ref_mul(4, longint'(a), longint'(b), tc);
        e.acc = cyc + 1;
        e.lat = ref_lat(4, longint'(b), tc);
        q4.push_back(e);
        @(negedge ck);
        bus4.start = 1'b0;
        bus4.a = 4'($urandom); bus4.b = 4'($urandom); bus4.tc = 1'($urandom);
        while (bus4.busy === 1'b1 && nb < 100) begin
            @(negedge ck);
            nb++;
        end
        chk("w4_busy_cycles", longint'(nb), longint'(e.lat + 1));
        @(negedge ck);
    endtask

    task automatic go8(input logic [7:0] a, input logic [7:0] b, input logic tc);
        exp_t e;
        @(negedge ck);
        bus8.start = 1'b1; bus8.a = a; bus8.b = b; bus8.tc = tc;
        e.p = ref_mul(8, longint'(a), longint'(b), tc);
        e.acc = cyc + 1;
        e.lat = ref_lat(8, longint'(b), tc);
        q8.push_back(e);
        @(negedge ck);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom); bus8.b = 8'($urandom);
        wait_idle8();
    endtask

    initial begin
        exp_t e;
        int   lat;
        int   t;
        longint last;
        bus4.start = 1'b0; bus4.tc = 1'b0; bus4.a = '0; bus4.b = '0;
        bus8.start = 1'b0; bus8.tc = 1'b0; bus8.a = '0; bus8.b = '0;

        // Reset state
        #12;
        chk("rst_busy", longint'(bus4.busy), 0);
        chk("rst_done", longint'(bus4.done), 0);
        chk("rst_p", longint'(bus4.p), 0);
        chk("rst_p8", longint'(bus8.p), 0);
        @(negedge ck);
        res = 1'b0;

        // Unsigned table
        go4(4'hF, 4'h1, 1'b0);
        go4(4'hF, 4'h8, 1'b0);
        go4(4'hF, 4'hF, 1'b0);
        go4(4'h8, 4'hA, 1'b0);
        // Early-exit corner operands (also valid for the fixed-latency build)
        go4(4'h5, 4'h0, 1'b0);
        go4(4'h7, 4'h1, 1'b0);
        go4(4'hF, 4'hA, 1'b0);
        // Signed table
        go4(4'hF, 4'hF, 1'b1);
        go4(4'h8, 4'hF, 1'b1);
        go4(4'h8, 4'h8, 1'b1);
        go4(4'h7, 4'h8, 1'b1);
        go4(4'h0, 4'h8, 1'b1);
        chk("w4_table_drained", longint'(q4.size()), 0);

        // Busy interlock: extra starts in CALC and FIN are ignored
        @(negedge ck);
        bus4.start = 1'b1; bus4.a = 4'h3; bus4.b = 4'h5; bus4.tc = 1'b0;
        lat = ref_lat(4, 5, 1'b0);
        e.p = 15; e.acc = cyc + 1; e.lat = lat;
        q4.push_back(e);
        @(negedge ck);
        bus4.start = 1'b0;
        @(negedge ck);
        bus4.start = 1'b1; bus4.a = 4'hF; bus4.b = 4'hF;
        @(negedge ck);
        bus4.start = 1'b0;
        repeat (lat - 3) @(negedge ck);
        bus4.start = 1'b1; bus4.a = 4'hF; bus4.b = 4'hF;
        @(negedge ck);
        bus4.start = 1'b0;
        wait_idle4();
        repeat (3) @(negedge ck);
        chk("w4_interlock_drained", longint'(q4.size()), 0);
        chk("w4_p_hold", longint'(bus4.p), 15);
        go4(4'h6, 4'h7, 1'b0);

        // Start held high: back-to-back accepts every lat+1 cycles
        @(negedge ck);
        bus4.start = 1'b1; bus4.a = 4'h5; bus4.b = 4'h6; bus4.tc = 1'b0;
        lat = ref_lat(4, 6, 1'b0);
        t = lat + 1;
        for (int k = 0; k < 3; k++) begin
            e.p = 30; e.acc = cyc + 1 + k * t; e.lat = lat;
            q4.push_back(e);
        end
        repeat (2 * t + 1) @(negedge ck);
        bus4.start = 1'b0;
        wait_idle4();
        chk("w4_b2b_drained", longint'(q4.size()), 0);

        // Reset abort mid-CALC
        @(negedge ck);
        bus4.start = 1'b1; bus4.a = 4'hF; bus4.b = 4'hF; bus4.tc = 1'b0;
        @(negedge ck);
        bus4.start = 1'b0;
        @(negedge ck);
        #2 res = 1'b1;
        #1;
        chk("abort_busy", longint'(bus4.busy), 0);
        chk("abort_done", longint'(bus4.done), 0);
        chk("abort_p", longint'(bus4.p), 0);
        @(negedge ck);
        res = 1'b0;
        repeat (10) @(negedge ck);
        go4(4'h9, 4'h3, 1'b0);
        chk("w4_abort_drained", longint'(q4.size()), 0);

        // WIDTH=8 random sweep, both modes
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 256; i++) go8(8'($urandom), 8'($urandom), 1'(m));
        end
        go8(8'h80, 8'h80, 1'b1);
        go8(8'hFF, 8'hFF, 1'b0);
        last = ref_mul(8, 255, 255, 1'b0);
        repeat (4) @(negedge ck);
        chk("w8_p_hold", longint'(bus8.p), last);
        chk("w8_drained", longint'(q8.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        chk("global_timeout", 1, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
